// File: rtl/seg_display_pkg.sv
// Shared definitions for the seven-segment display responder: register map,
// CTRL bit positions, bus FSM states and segment drive constants.
package seg_display_pkg;

  localparam logic [7:0] REG_DATA   = 8'h00;
  localparam logic [7:0] REG_DPMASK = 8'h04;
  localparam logic [7:0] REG_CTRL   = 8'h08;

  localparam int CTRL_EN   = 0;
  localparam int CTRL_LAMP = 1;

  typedef enum logic {IDLE, ACK} fsm_t;

  localparam logic [7:0] SEG_BLANK  = 8'hFF;
  localparam logic [7:0] SEG_ALL_ON = 8'h00;

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational nibble to active-low a..g decoder (seg[0] = a, seg[6] = g).
module hex_to_seg7 (
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  always_comb begin
    seg = 7'h7F;
    case (nibble)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      4'hF: seg = 7'h0E;
      default: seg = 7'h7F;
    endcase
  end

endmodule

// File: rtl/seg_display_responder.sv
// Memory-mapped 8-digit seven-segment display responder on the shared tri-state bus.
// Optional macro SEG_LEADING_ZERO_BLANK_EN blanks leading zero digits.
module seg_display_responder
  import seg_display_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'hFFFF_FF00,
  parameter int          REFRESH_DIV = 50000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        input_enable,
  input  logic        write_enable,
  input  logic [31:0] address,
  inout  wire  [31:0] bus,
  output logic        done_or_valid,
  output logic [2:0]  select,
  output logic [7:0]  segments
);

  localparam int CNT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;

  fsm_t              state;
  logic [31:0]       data_reg;
  logic [7:0]        dpmask_reg;
  logic [1:0]        ctrl_reg;
  logic [31:0]       rdata_p0;
  logic              drive_p0;
  logic [31:0]       read_word;
  logic [7:0]        reg_off;
  logic              hit;
  logic              unused_addr;

  logic [CNT_W-1:0]  cnt_p0;
  logic [2:0]        idx_p0;
  logic [2:0]        next_idx;
  logic [3:0]        nib;
  logic [6:0]        seg7;
  logic              blank_lz;
  logic [7:0]        seg_next;

  assign hit         = input_enable && (address[31:8] == BASE_ADDR[31:8]);
  assign reg_off     = {address[7:2], 2'b00};
  assign unused_addr = ^address[1:0];

  always_comb begin
    read_word = '0;
    case (reg_off)
      REG_DATA:   read_word = data_reg;
      REG_DPMASK: read_word = {24'h0, dpmask_reg};
      REG_CTRL:   read_word = {30'h0, ctrl_reg};
      default:    read_word = '0;
    endcase
  end

  // Bus stage: request sampled in IDLE, acknowledged one cycle later in ACK
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      done_or_valid <= 1'b0;
      drive_p0      <= 1'b0;
      rdata_p0      <= '0;
      data_reg      <= '0;
      dpmask_reg    <= '0;
      ctrl_reg      <= 2'b01;
    end else begin
      case (state)
        IDLE: begin
          if (hit) begin
            state         <= ACK;
            done_or_valid <= 1'b1;
            drive_p0      <= !write_enable;
            if (write_enable) begin
              case (reg_off)
                REG_DATA:   data_reg   <= bus;
                REG_DPMASK: dpmask_reg <= bus[7:0];
                REG_CTRL:   ctrl_reg   <= bus[1:0];
                default:    ;
              endcase
            end else begin
              rdata_p0 <= read_word;
            end
          end
        end
        ACK: begin
          // Four-phase: wait for the initiator to drop the strobe before rearming
          if (!input_enable) begin
            state         <= IDLE;
            done_or_valid <= 1'b0;
            drive_p0      <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus = (drive_p0 && !reset) ? rdata_p0 : 32'bz;

  // Scan stage: the next digit's drive is computed and latched at the slot boundary
  assign next_idx = idx_p0 + 3'd1;
  assign nib      = data_reg[{next_idx, 2'b00} +: 4];

  hex_to_seg7 u_dec (
    .nibble (nib),
    .seg    (seg7)
  );

`ifdef SEG_LEADING_ZERO_BLANK_EN
  assign blank_lz = (next_idx != 3'd0) && !dpmask_reg[next_idx] &&
                    ((data_reg >> {next_idx, 2'b00}) == 32'h0);
`else
  assign blank_lz = 1'b0;
`endif

  always_comb begin
    seg_next = {~dpmask_reg[next_idx], seg7};
    if (ctrl_reg[CTRL_LAMP])
      seg_next = SEG_ALL_ON;
    else if (!ctrl_reg[CTRL_EN] || blank_lz)
      seg_next = SEG_BLANK;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_p0   <= '0;
      idx_p0   <= '0;
      segments <= SEG_BLANK;
    end else if (cnt_p0 == CNT_W'(REFRESH_DIV - 1)) begin
      cnt_p0   <= '0;
      idx_p0   <= next_idx;
      segments <= seg_next;
    end else begin
      cnt_p0 <= cnt_p0 + CNT_W'(1);
    end
  end

  assign select = idx_p0;

endmodule

// File: tb/tb_seg_display_responder.sv
// Self-checking bench for seg_display_responder: vector table, scan model,
// randomized register traffic and reset-in-flight sequence.
module tb_seg_display_responder;

  localparam int          RDIV = 4;
  localparam logic [31:0] BASE = 32'hFFFF_FF00;
  localparam logic [31:0] PULL = 32'hFFFF_FFFF;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        input_enable = 1'b0;
  logic        write_enable = 1'b0;
  logic [31:0] address = '0;
  logic        tb_oe = 1'b0;
  logic [31:0] tb_wdata = '0;
  wire  [31:0] bus;
  logic        done_or_valid;
  logic [2:0]  select;
  logic [7:0]  segments;

  int total = 0;
  int bad = 0;
  int n = 0;

  logic [31:0] m_data = '0;
  logic [7:0]  m_dp = '0;
  logic [1:0]  m_ctrl = 2'b01;

  logic [6:0] hex7 [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                            7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  assign bus = tb_oe ? tb_wdata : 32'bz;
  for (genvar g = 0; g < 32; g++) begin : g_pu
    pullup (bus[g]);
  end

  seg_display_responder #(.BASE_ADDR(BASE), .REFRESH_DIV(RDIV)) dut (
    .clock         (clock),
    .reset         (reset),
    .input_enable  (input_enable),
    .write_enable  (write_enable),
    .address       (address),
    .bus           (bus),
    .done_or_valid (done_or_valid),
    .select        (select),
    .segments      (segments)
  );

  always #5 clock = ~clock;

  always @(posedge clock or posedge reset) begin
    if (reset) n <= 0;
    else n <= n + 1;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] model_read(input logic [31:0] a);
    case (a[7:0] & 8'hFC)
      8'h00:   return m_data;
      8'h04:   return {24'h0, m_dp};
      8'h08:   return {30'h0, m_ctrl};
      default: return 32'h0;
    endcase
  endfunction

  function automatic void model_write(input logic [31:0] a, input logic [31:0] d);
    case (a[7:0] & 8'hFC)
      8'h00:   m_data = d;
      8'h04:   m_dp = d[7:0];
      8'h08:   m_ctrl = d[1:0];
      default: ;
    endcase
  endfunction

  function automatic logic [7:0] exp_seg(input int d);
    logic [3:0] nb;
    nb = 4'((m_data >> (4 * d)) & 32'hF);
    if (m_ctrl[1]) return 8'h00;
    if (!m_ctrl[0]) return 8'hFF;
`ifdef SEG_LEADING_ZERO_BLANK_EN
    if (d != 0 && !m_dp[d] && (m_data >> (4 * d)) == 32'h0) return 8'hFF;
`endif
    return {~m_dp[d], hex7[nb]};
  endfunction

  task automatic do_req(input logic [31:0] a, input logic we, input logic [31:0] wd,
                        input logic ack, input logic [31:0] rd, input string nm);
    @(negedge clock);
    address = a; write_enable = we; input_enable = 1'b1; tb_oe = we; tb_wdata = wd;
    if (ack) begin
      @(negedge clock);
      chk({nm, " ack"}, 32'(done_or_valid), 32'h1);
      if (!we) chk({nm, " rdata"}, bus, rd);
      input_enable = 1'b0; tb_oe = 1'b0;
      @(negedge clock);
      chk({nm, " done drop"}, 32'(done_or_valid), 32'h0);
      chk({nm, " release"}, bus, PULL);
    end else begin
      for (int i = 0; i < 10; i++) begin
        @(negedge clock);
        chk({nm, " no ack"}, 32'(done_or_valid), 32'h0);
        if (!we) chk({nm, " bus z"}, bus, PULL);
      end
      input_enable = 1'b0; tb_oe = 1'b0;
    end
  endtask

  task automatic wr(input logic [31:0] off, input logic [31:0] d);
    do_req(BASE + off, 1'b1, d, 1'b1, 32'h0, "wr");
    model_write(BASE + off, d);
  endtask

  task automatic rd(input logic [31:0] off);
    do_req(BASE + off, 1'b0, 32'h0, 1'b1, model_read(BASE + off), "rd");
  endtask

  task automatic wait_slot();
    logic [2:0] s0;
    bit seen;
    s0 = select; seen = 0;
    for (int i = 0; i < 2 * RDIV + 2 && !seen; i++) begin
      @(negedge clock);
      if (select != s0) seen = 1;
    end
    if (!seen) begin
      total++; bad++;
      $display("FAIL wait_slot: select stuck at %0d", s0);
    end
  endtask

  task automatic wait_sel(input logic [2:0] v);
    bit seen;
    seen = (select == v);
    for (int i = 0; i < 10 * RDIV && !seen; i++) begin
      @(negedge clock);
      if (select == v) seen = 1;
    end
    if (!seen) begin
      total++; bad++;
      $display("FAIL wait_sel: select %0d never reached %0d", select, v);
    end
  endtask

  task automatic check_scan(input int cycles, input string nm);
    int d;
    for (int i = 0; i < cycles; i++) begin
      d = (n / RDIV) % 8;
      chk({nm, " select"}, 32'(select), 32'(d));
      chk({nm, " segments"}, 32'(segments), 32'(exp_seg(d)));
      @(negedge clock);
    end
  endtask

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wd;
    logic        ack;
    logic [31:0] rd;
  } vec_t;

  vec_t tbl [16];

  initial begin
    logic [31:0] rd_data;
    tbl[0]  = '{BASE + 32'h08, 1'b0, 32'h0,         1'b1, 32'h0000_0001};
    tbl[1]  = '{BASE + 32'h00, 1'b0, 32'h0,         1'b1, 32'h0000_0000};
    tbl[2]  = '{BASE + 32'h04, 1'b0, 32'h0,         1'b1, 32'h0000_0000};
    tbl[3]  = '{BASE + 32'h20, 1'b0, 32'h0,         1'b1, 32'h0000_0000};
    tbl[4]  = '{32'h0000_1000, 1'b0, 32'h0,         1'b0, 32'h0};
    tbl[5]  = '{BASE + 32'h00, 1'b1, 32'h1234_5678, 1'b1, 32'h0};
    tbl[6]  = '{BASE + 32'h00, 1'b0, 32'h0,         1'b1, 32'h1234_5678};
    tbl[7]  = '{BASE + 32'h04, 1'b1, 32'h0000_01A5, 1'b1, 32'h0};
    tbl[8]  = '{BASE + 32'h04, 1'b0, 32'h0,         1'b1, 32'h0000_00A5};
    tbl[9]  = '{BASE + 32'h08, 1'b1, 32'hFFFF_FFFE, 1'b1, 32'h0};
    tbl[10] = '{BASE + 32'h08, 1'b0, 32'h0,         1'b1, 32'h0000_0002};
    tbl[11] = '{BASE + 32'h20, 1'b1, 32'hDEAD_BEEF, 1'b1, 32'h0};
    tbl[12] = '{BASE + 32'h20, 1'b0, 32'h0,         1'b1, 32'h0000_0000};
    tbl[13] = '{32'hFFFF_FE08, 1'b1, 32'h0000_0003, 1'b0, 32'h0};
    tbl[14] = '{BASE + 32'h08, 1'b0, 32'h0,         1'b1, 32'h0000_0002};
    tbl[15] = '{BASE + 32'h08, 1'b1, 32'h0000_0001, 1'b1, 32'h0};

    repeat (3) @(negedge clock);
    chk("reset done", 32'(done_or_valid), 32'h0);
    chk("reset select", 32'(select), 32'h0);
    chk("reset segments", 32'(segments), 32'hFF);
    chk("reset bus", bus, PULL);
    reset = 1'b0;

    for (int i = 0; i < 16; i++) begin
      do_req(tbl[i].addr, tbl[i].we, tbl[i].wd, tbl[i].ack, tbl[i].rd, $sformatf("vec%0d", i));
      if (tbl[i].we && tbl[i].ack) model_write(tbl[i].addr, tbl[i].wd);
    end

    // Request held through ACK while bus data changes must not be re-executed
    @(negedge clock);
    address = BASE; write_enable = 1'b1; input_enable = 1'b1; tb_oe = 1'b1; tb_wdata = 32'h0000_AAAA;
    @(negedge clock);
    chk("hold ack", 32'(done_or_valid), 32'h1);
    tb_wdata = 32'h0000_BBBB;
    repeat (3) begin
      @(negedge clock);
      chk("hold done", 32'(done_or_valid), 32'h1);
    end
    input_enable = 1'b0; tb_oe = 1'b0;
    model_write(BASE, 32'h0000_AAAA);
    rd(32'h00);

    // Scan over a known value, plain then with dp, lamp test and disable
    wr(32'h04, 32'h0);
    wr(32'h00, 32'h1234_5678);
    wait_slot();
    check_scan(8 * RDIV * 2, "scan plain");
    wait_sel(3'd0);
    chk("digit0 is 8", 32'(segments), 32'h80);
    wait_sel(3'd1);
    chk("digit1 is 7", 32'(segments), 32'hF8);
    wait_sel(3'd7);
    chk("digit7 is 1", 32'(segments), 32'hF9);
    wait_sel(3'd0);
    chk("wrap to 0", 32'(select), 32'h0);
    wr(32'h04, 32'h01);
    wait_slot();
    check_scan(8 * RDIV, "scan dp");
    wr(32'h08, 32'h2);
    wait_slot();
    check_scan(8 * RDIV, "scan lamp");
    wr(32'h08, 32'h0);
    wait_slot();
    check_scan(8 * RDIV, "scan off");
    wr(32'h08, 32'h3);
    wait_slot();
    check_scan(8 * RDIV, "scan lamp+en");
    wr(32'h08, 32'h1);

    // Leading zero patterns (blanked only when the feature is built in)
    wr(32'h04, 32'h0);
    wr(32'h00, 32'h0000_0A05);
    wait_slot();
    check_scan(8 * RDIV, "lz 0a05");
    wr(32'h00, 32'h0);
    wait_slot();
    check_scan(8 * RDIV, "lz zero");
    wr(32'h04, 32'h20);
    wr(32'h00, 32'h0000_00F0);
    wait_slot();
    check_scan(8 * RDIV, "lz dp");

    // Randomized register traffic against the model
    for (int it = 0; it < 8; it++) begin
      logic [31:0] d;
      d = $urandom;
      d = d >> (4 * $urandom_range(0, 7));
      wr(32'h00, d);
      wr(32'h04, $urandom);
      wr(32'h08, ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : 32'h1);
      for (int k = 0; k < 3; k++) rd(32'($urandom_range(0, 63)) << 2);
      wait_slot();
      check_scan(8 * RDIV + 3, "rand scan");
    end

    // Reset while a read is being acknowledged
    wr(32'h00, 32'hCAFE_0001);
    @(negedge clock);
    address = BASE; write_enable = 1'b0; input_enable = 1'b1; tb_oe = 1'b0;
    @(negedge clock);
    chk("pre-reset ack", 32'(done_or_valid), 32'h1);
    chk("pre-reset rdata", bus, 32'hCAFE_0001);
    #2 reset = 1'b1;
    #1;
    chk("async rst done", 32'(done_or_valid), 32'h0);
    chk("async rst bus", bus, PULL);
    chk("async rst seg", 32'(segments), 32'hFF);
    chk("async rst sel", 32'(select), 32'h0);
    @(negedge clock);
    input_enable = 1'b0;
    reset = 1'b0;
    m_data = '0; m_dp = '0; m_ctrl = 2'b01;
    rd(32'h00);
    rd(32'h08);
    do_req(BASE, 1'b0, 32'h0, 1'b1, 32'h0, "post-reset data");
    rd_data = bus;
    chk("post-reset idle bus", rd_data, PULL);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: total=%0d", total);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/seg_display_responder.md
Name: seg_display_responder

Overview:
- Memory-mapped seven-segment display peripheral on the shared 32-bit tri-state bus.
- Acts as a responder to the control unit's memory-request handshake (input_enable / done_or_valid), alongside the BRAM responder.
- Holds an 8-digit hex value, a decimal-point mask and a control register.
- Time-multiplexes the value onto an 8-digit display through a 3-bit digit select and an 8-bit segment drive.

Parameters:
- BASE_ADDR, 32'hFFFF_FF00: base of the 256-byte register window; word aligned.
- REFRESH_DIV, 50000: clock cycles per digit slot; must be >= 2.

Ports:
- clock  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- input_enable  input  1  request strobe from the initiator; held high until done_or_valid is seen.
- write_enable  input  1  1 = write, 0 = read; valid while input_enable is high.
- address  input  32  byte address; valid while input_enable is high.
- bus  inout  32  shared tri-state data bus; write data in, read data out.
- done_or_valid  output  1  completion/acknowledge to the initiator.
- select  output  3  binary index of the active digit (0 = rightmost).
- segments  output  8  active-low segment drive: [6:0] = a..g, [7] = dp.

Behaviour:
- Registers, at word offsets from BASE_ADDR:
  - 0x00 DATA[31:0]: digit i = DATA[4i+3:4i]. Reset value 0.
  - 0x04 DPMASK[7:0]: bit i lights the dp of digit i. Upper bits read 0. Reset value 0.
  - 0x08 CTRL[1:0]: bit0 = enable, bit1 = lamp test. Reset value 2'b01.
  - Other offsets inside the window: writes ignored, reads return 0, still acknowledged.
- Decode: hit = input_enable && address[31:8] == BASE_ADDR[31:8]. Addresses outside the window get no response: bus stays high-Z and done_or_valid stays 0.
- FSM states: IDLE, ACK.
  - IDLE -> ACK on the rising edge where hit is sampled.
  - Write: DATA, DPMASK or CTRL updates on that same edge, using address[7:2] and the bus value.
  - Read: the read word is latched on that same edge.
  - ACK: done_or_valid = 1. On a read, bus is driven with the latched word during ACK only.
  - ACK -> IDLE on the first edge where input_enable = 0.
  - Net latency: one cycle from request to done_or_valid.
- Four-phase handshake: a new request is not accepted until input_enable has returned low. A request held high through ACK is not re-executed.
- bus is high-Z in IDLE, during write ACKs, and whenever reset is asserted.
- Scan:
  - Prescaler counts 0..REFRESH_DIV-1; on wrap, digit index increments mod 8 (7 -> 0).
  - select = digit index, registered.
  - segments = registered hex-to-7-seg decode of the current nibble, with dp from DPMASK. The decode covers the full 0-F table: 0 = 8'b1100_0000 with dp off, F = 8'b1000_1110.
- Priority: lamp test overrides everything (segments = 8'h00). Otherwise enable = 0 gives segments = 8'hFF (blank). Scanning continues in both cases.
- A DATA write takes effect from the next digit slot after the write edge. No tearing within a slot: the nibble is sampled when the slot starts.
- Reset (async, any time, including mid-transaction):
  - FSM = IDLE, done_or_valid = 0, bus released.
  - Prescaler and index = 0, select = 0, segments = 8'hFF.
  - Registers return to their reset values.
  - An interrupted transaction is lost; the initiator re-issues it.

Optional Feature:
- Macro: SEG_LEADING_ZERO_BLANK_EN.
- When defined:
  - A digit is blanked (segments = 8'hFF) when it and every higher digit are zero.
  - Digit 0 is never blanked.
  - A digit whose DPMASK bit is set is never blanked.
  - Lamp test still overrides.
- When undefined: all eight digits always display.

Decomposition:
- Package seg_display_pkg holds:
  - register offset constants (REG_DATA, REG_DPMASK, REG_CTRL);
  - CTRL bit index constants;
  - the fsm typedef enum {IDLE, ACK};
  - SEG_BLANK = 8'hFF and SEG_ALL_ON = 8'h00.
- One sub-module, hex_to_seg7: a combinational nibble-to-active-low a..g decoder, instantiated once on the scan path.

Test Plan:
- Reset, then read 0x08 -> done_or_valid rises one cycle after the request; bus = 32'h1 while done_or_valid is high; high-Z after input_enable drops. Reads of 0x00 and 0x04 return 0.
- Write 32'h1234_5678 to DATA (REFRESH_DIV = 4) -> select steps 0..7 every 4 cycles. Segments follow: 8 = 8'h80, 7 = 8'hF8, ..., 1 = 8'hF9; select wraps 7 -> 0.
- Write DPMASK = 8'h01, then CTRL = 2'b10 -> digit 0 shows dp (bit7 = 0). After CTRL write, segments = 8'h00 on every digit. CTRL = 0 gives 8'hFF on every digit.
- Access 32'h0000_1000 with input_enable held 10 cycles -> done_or_valid stays 0 and bus stays Z. Read offset 0x20 -> acknowledged, returns 0.
- Assert reset while done_or_valid = 1 on a read -> done_or_valid and bus release immediately, segments = 8'hFF, DATA = 0 afterwards.
- With SEG_LEADING_ZERO_BLANK_EN and DATA = 32'h0000_0A05 -> digits 7..3 blank (8'hFF); digits 2..0 show A, 0, 5. With DATA = 0, only digit 0 shows 0.
